// File: rtl/vga_pixel_fetch.sv
// Prefetching pixel feeder: streams grayscale bytes from a 1-cycle-latency image
// memory through a small FIFO and replicates each popped byte onto R/G/B.
module vga_pixel_fetch #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAMES     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              pix_req,
  output logic              pix_valid,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              underflow,
  output logic              done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FRM_W = $clog2(FRAMES + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    FULL_OCC   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [FRM_W-1:0]  LAST_FRAME = FRM_W'(FRAMES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [7:0]        pix_q, pix_d;
  logic              pix_valid_q, pix_valid_d;
  logic              underflow_q, underflow_d;
  logic              done_q, done_d;

  logic              serving;
  logic              pop;
  logic              starve;
  logic              rd;
  logic              last_read;
  logic [CNT_W:0]    occ;

  // Occupancy seen by the read issuer counts the in-flight byte and credits this cycle's pop.
  always_comb begin
    serving   = (state_q == S_STREAM) || (state_q == S_DRAIN);
    pop       = serving && pix_req && (count_q != '0);
    starve    = serving && pix_req && (count_q == '0);
    occ       = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    rd        = ((state_q == S_FILL) || (state_q == S_STREAM)) && (occ < FULL_OCC);
    last_read = rd && (addr_q == LAST_ADDR) && (frame_q == LAST_FRAME);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frame_d     = frame_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = rd;
    fifo_d      = fifo_q;
    pix_d       = pix_q;
    pix_valid_d = pop;
    underflow_d = underflow_q | starve;

    // Returned read data lands one cycle after the strobe.
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = mem_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      pix_d    = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (starve) begin
      pix_d = 8'h00;
    end
    count_d = count_q + CNT_W'(inflight_q) - CNT_W'(pop);

    if (rd) begin
      if (addr_q == LAST_ADDR) begin
        addr_d  = '0;
        frame_d = frame_q + FRM_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          addr_d  = '0;
          frame_d = '0;
        end
      end
      S_FILL: begin
        if (last_read)               state_d = S_DRAIN;
        else if (count_d == FULL_CNT) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (last_read) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((count_q == '0) && !inflight_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      frame_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      fifo_q      <= '{default: '0};
      pix_q       <= 8'h00;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      frame_q     <= frame_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      fifo_q      <= fifo_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
    end
  end

  // The read strobe must react to a same-cycle pop, so it is decoded rather than registered.
  assign mem_rd    = rd;
  assign mem_addr  = addr_q;
  assign pix_valid = pix_valid_q;
  assign R         = pix_q;
  assign G         = pix_q;
  assign B         = pix_q;
  assign underflow = underflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboarded bench: dut 0 streams one 4x2 frame, dut 1 streams two frames.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned AW = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          start [2];
  logic          req   [2];
  logic          rd    [2];
  logic [AW-1:0] addr  [2];
  logic [7:0]    data  [2];
  logic          pv    [2];
  logic [7:0]    r     [2];
  logic [7:0]    g     [2];
  logic [7:0]    b     [2];
  logic          uf    [2];
  logic          dn    [2];

  int checks = 0;
  int passed = 0;
  logic [7:0]    exp_pix0  [$];
  logic [7:0]    exp_pix1  [$];
  logic [AW-1:0] exp_addr0 [$];
  logic [AW-1:0] exp_addr1 [$];
  bit done_seen1;

  always #10 clk = ~clk;

  // Image memory model: byte at address i is 0x10+i, one-cycle read latency.
  always @(posedge clk) begin
    if (rd[0]) data[0] <= 8'h10 + 8'(addr[0]);
    if (rd[1]) data[1] <= 8'h10 + 8'(addr[1]);
  end

  vga_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .FRAMES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .mem_rd(rd[0]), .mem_addr(addr[0]),
    .mem_data(data[0]), .pix_req(req[0]), .pix_valid(pv[0]), .R(r[0]), .G(g[0]), .B(b[0]),
    .underflow(uf[0]), .done(dn[0]));

  vga_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .FRAMES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .mem_rd(rd[1]), .mem_addr(addr[1]),
    .mem_data(data[1]), .pix_req(req[1]), .pix_valid(pv[1]), .R(r[1]), .G(g[1]), .B(b[1]),
    .underflow(uf[1]), .done(dn[1]));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void chk_pix(int d, logic [7:0] e);
    chk($sformatf("d%0d pixel R", d), 32'(r[d]), 32'(e));
    chk($sformatf("d%0d pixel G", d), 32'(g[d]), 32'(e));
    chk($sformatf("d%0d pixel B", d), 32'(b[d]), 32'(e));
  endfunction

  // Expected stream for n frames: addresses 0..NPIX-1 repeated, pixel = 0x10+address.
  function automatic void push_frames(int d, int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < int'(NPIX); i++) begin
        if (d == 0) begin exp_pix0.push_back(8'h10 + 8'(i)); exp_addr0.push_back(AW'(i)); end
        else        begin exp_pix1.push_back(8'h10 + 8'(i)); exp_addr1.push_back(AW'(i)); end
      end
  endfunction

  function automatic void chk_reset_outputs(int d, string tag);
    chk({tag, " mem_rd"},    32'(rd[d]),   32'd0);
    chk({tag, " mem_addr"},  32'(addr[d]), 32'd0);
    chk({tag, " pix_valid"}, 32'(pv[d]),   32'd0);
    chk({tag, " R"},         32'(r[d]),    32'd0);
    chk({tag, " G"},         32'(g[d]),    32'd0);
    chk({tag, " B"},         32'(b[d]),    32'd0);
    chk({tag, " underflow"}, 32'(uf[d]),   32'd0);
    chk({tag, " done"},      32'(dn[d]),   32'd0);
  endfunction

  // Monitor: sampled just before each rising edge.
  initial forever begin
    @(negedge clk); #8;
    if (!rst) begin
      if (pv[0]) begin
        if (exp_pix0.size() == 0) chk("d0 unexpected pixel", 32'd1, 32'd0);
        else chk_pix(0, exp_pix0.pop_front());
      end
      if (pv[1]) begin
        if (exp_pix1.size() == 0) chk("d1 unexpected pixel", 32'd1, 32'd0);
        else chk_pix(1, exp_pix1.pop_front());
      end
      if (rd[0]) begin
        if (exp_addr0.size() == 0) chk("d0 unexpected read", 32'd1, 32'd0);
        else chk("d0 read addr", 32'(addr[0]), 32'(exp_addr0.pop_front()));
      end
      if (rd[1]) begin
        if (exp_addr1.size() == 0) chk("d1 unexpected read", 32'd1, 32'd0);
        else chk("d1 read addr", 32'(addr[1]), 32'(exp_addr1.pop_front()));
      end
      if (dn[1] && !done_seen1) begin
        done_seen1 = 1'b1;
        chk("d1 pixels left at done", 32'(exp_pix1.size()), 32'd0);
      end
      chk("d0 occupancy bound", 32'(u_dut0.count_q <= 3'(DEPTH)), 32'd1);
      chk("d1 occupancy bound", 32'(u_dut1.count_q <= 3'(DEPTH)), 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; req[d] = 1'b0; end
    exp_pix0.delete(); exp_pix1.delete(); exp_addr0.delete(); exp_addr1.delete();
    done_seen1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_done(int d, bit random_req, int budget);
    int k;
    k = 0;
    while (!dn[d] && k < budget) begin
      @(negedge clk);
      start[d] = 1'b0;
      req[d] = random_req ? 1'($urandom_range(0, 1)) : 1'b1;
      k++;
    end
    if (!dn[d]) chk($sformatf("d%0d timeout waiting for done", d), 32'd0, 32'd1);
    @(negedge clk); req[d] = 1'b0; #8;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; req[d] = 1'b0; end
    done_seen1 = 1'b0;
    repeat (2) @(negedge clk);
    #8;
    chk_reset_outputs(0, "d0 reset");
    chk_reset_outputs(1, "d1 reset");
    @(negedge clk); rst = 1'b0;

    // Fill with no requests: four back-to-back reads, then quiet.
    @(negedge clk); start[0] = 1'b1; push_frames(0, 1); #8;
    chk("d0 idle no read", 32'(rd[0]), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); start[0] = 1'b0; #8;
      chk($sformatf("d0 fill strobe c%0d", k), 32'(rd[0]), 32'(k <= 4));
    end
    // Full FIFO plus a pop admits a read that same cycle; then 8 pops.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); req[0] = 1'b1; #8;
      if (k == 0) begin
        chk("d0 full+pop read", 32'(rd[0]), 32'd1);
        chk("d0 full+pop addr", 32'(addr[0]), 32'd4);
      end
    end
    @(negedge clk); req[0] = 1'b0; #8;
    chk("d0 done one cycle after last pop", 32'(dn[0]), 32'd0);
    chk("d0 last pixel valid", 32'(pv[0]), 32'd1);
    @(negedge clk); #8;
    chk("d0 done two cycles after last pop", 32'(dn[0]), 32'd1);
    chk("d0 no underflow", 32'(uf[0]), 32'd0);
    chk("d0 pixels left", 32'(exp_pix0.size()), 32'd0);
    chk("d0 reads left", 32'(exp_addr0.size()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req[0] = 1'b1; start[0] = (k == 0); #8;
      chk("d0 done no read", 32'(rd[0]), 32'd0);
      chk("d0 done no pop", 32'(pv[0]), 32'd0);
      chk("d0 done ignores req", 32'(uf[0]), 32'd0);
      chk("d0 done held", 32'(dn[0]), 32'd1);
    end

    // Requests held from just after start: drain hits an empty FIFO once.
    do_reset();
    @(negedge clk); start[0] = 1'b1; push_frames(0, 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); start[0] = 1'b0; req[0] = 1'b1; #8;
      if (k == 14) chk("d0 pre-starve underflow", 32'(uf[0]), 32'd0);
      if (k == 15) begin
        chk("d0 starve underflow", 32'(uf[0]), 32'd1);
        chk("d0 starve pix_valid", 32'(pv[0]), 32'd0);
        chk("d0 starve RGB zero", 32'({r[0], g[0], b[0]}), 32'd0);
        chk("d0 starve done", 32'(dn[0]), 32'd1);
      end
      if (k == 20) chk("d0 underflow sticky", 32'(uf[0]), 32'd1);
    end
    chk("d0 starve run pixels left", 32'(exp_pix0.size()), 32'd0);
    do_reset(); #8;
    chk("d0 underflow cleared by rst", 32'(uf[0]), 32'd0);

    // Async reset mid-stream at address 5, then restart from 0.
    @(negedge clk); start[0] = 1'b1; push_frames(0, 1);
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk); start[0] = 1'b0; req[0] = 1'b1; #8; k++;
      end while (!(addr[0] == AW'(5) && pv[0]) && k < 40);
      if (k >= 40) chk("d0 timeout reaching addr 5", 32'd0, 32'd1);
    end
    rst = 1'b1; #1;
    chk_reset_outputs(0, "d0 async reset");
    exp_pix0.delete(); exp_addr0.delete();
    req[0] = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start[0] = 1'b1; push_frames(0, 1);
    @(negedge clk); start[0] = 1'b0; #8;
    chk("d0 restart read", 32'(rd[0]), 32'd1);
    chk("d0 restart addr", 32'(addr[0]), 32'd0);
    run_to_done(0, 1'b0, 60);
    chk("d0 restart pixels left", 32'(exp_pix0.size()), 32'd0);

    // Two frames, continuous requests.
    do_reset();
    @(negedge clk); start[1] = 1'b1; push_frames(1, 2);
    run_to_done(1, 1'b0, 100);
    chk("d1 pixels left", 32'(exp_pix1.size()), 32'd0);
    chk("d1 reads left", 32'(exp_addr1.size()), 32'd0);

    // Two frames, random requests.
    for (int n = 0; n < 3; n++) begin
      do_reset();
      @(negedge clk); start[1] = 1'b1; push_frames(1, 2);
      run_to_done(1, 1'b1, 400);
      chk("d1 random pixels left", 32'(exp_pix1.size()), 32'd0);
      chk("d1 random reads left", 32'(exp_addr1.size()), 32'd0);
      chk("d1 random done", 32'(dn[1]), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
